mem_str_fwd_ctrl: RTL and testbench
===================================

Name: mem_str_fwd_ctrl

Overview:
- Forwarding controller for the memory-stage store-data select mux.
- Generates the two 5-bit one-hot selects (top nibble, bottom byte) for the store's data sources in the EX/MEM stage, using:
  - the MEM/WB write destinations;
  - an internally kept one-cycle-older write history (the "tm1" slot).
- Also detects the store-after-load hazard and holds the upstream pipeline for one cycle until the load data reaches the tm1 slot.

Parameters:
- REG_ADDR_W, 4: register address width.
- ZERO_REG_HW, 1: when 1, address 0 is hardwired and never matches a forwarding source.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_in  in  1  global pipeline stall; freezes history and FSM.
- flush  in  1  squash: clears tm1 history valids and forces FSM to RUN.
- ex_mem_str_valid  in  1  a store occupies EX/MEM.
- ex_mem_src_top_addr  in  REG_ADDR_W  source register for store data bits [11:8].
- ex_mem_src_bot_addr  in  REG_ADDR_W  source register for store data bits [7:0].
- mem_wb_wr_top_en  in  1  MEM/WB writes its top result.
- mem_wb_wr_top_addr  in  REG_ADDR_W  destination of MEM/WB top result.
- mem_wb_wr_bot_en  in  1  MEM/WB writes its bottom result.
- mem_wb_wr_bot_addr  in  REG_ADDR_W  destination of MEM/WB bottom result.
- mem_wb_is_load  in  1  MEM/WB result data is not valid until next cycle.
- sel_signal_top  out  5  one-hot select for mem_data[11:8].
- sel_signal_bot  out  5  one-hot select for mem_data[7:0].
- fwd_hold  out  1  hold IF..EX/MEM for this cycle (MEM/WB keeps advancing).

Behaviour:
- Select encoding, identical for both outputs:
  - bit0: ex_mem own data;
  - bit1: mem_wb_top;
  - bit2: mem_wb_bot;
  - bit3: tm1_top;
  - bit4: tm1_bot.
- Selects are combinational from the inputs plus history registers; zero-cycle latency.
- Each output is always exactly one-hot while ex_mem_str_valid=1, and 5'b00001 when ex_mem_str_valid=0.
- Match rule: a source matches a slot when the slot's enable/valid is 1, the addresses are equal, and NOT (ZERO_REG_HW and addr==0).
- Priority, newest first: mem_wb_top > mem_wb_bot > tm1_top > tm1_bot > ex_mem (bit0). Top and bottom are resolved independently with the same rule.
- History registers: tm1_top_v/addr and tm1_bot_v/addr.
  - On each edge with stall_in=0 and flush=0, they load the mem_wb enables and addresses.
  - stall_in=1 holds them.
  - flush=1 clears both valids; flush has priority over stall_in.
- FSM states: RUN, HOLD. Reset state is RUN.
- RUN -> HOLD when all of: ex_mem_str_valid, mem_wb_is_load, a mem_wb slot is the selected match for top or bottom, and stall_in=0.
- HOLD -> RUN unconditionally on the next non-stalled edge.
- stall_in=1 freezes the state.
- flush forces RUN.
- fwd_hold = 1 combinationally in RUN whenever the RUN->HOLD condition is true (same cycle as the detection); 0 in HOLD.
  - While fwd_hold=1, the selects still show the mem_wb match; downstream ignores the store that cycle.
  - In HOLD, the load's write has shifted into tm1, so the selects show bit3/bit4.
- Reset (async, reset_n=0): tm1 valids=0, tm1 addresses=0, FSM=RUN.
  - Outputs during reset: sel_signal_top=sel_signal_bot=5'b00001 (since history is invalid and combinational inputs still apply; the bench holds ex_mem_str_valid=0 during reset), fwd_hold=0.
- Reset mid-HOLD returns to RUN immediately, with history cleared.
- A load in MEM/WB that matches nothing raises no hold.
- A hold is raised at most once per store, because HOLD never re-triggers.

Decomposition:
- Shared package (fwd_pkg):
  - SEL_EXMEM=5'b00001, SEL_WB_TOP=5'b00010, SEL_WB_BOT=5'b00100, SEL_TM1_TOP=5'b01000, SEL_TM1_BOT=5'b10000;
  - FSM state constants RUN/HOLD;
  - REG_ADDR_W default.
- Sub-module fwd_src_prio: purely combinational. Takes one source address plus four slot (valid, addr) pairs and returns a one-hot select. It is instantiated twice (top, bottom).

Test Plan:
- Reset with no stimulus -> both selects 5'b00001, fwd_hold=0; after release with str_valid=1 and no writes -> still 00001.
- Store src_bot=3 while mem_wb_wr_bot_en=1 with addr 3 -> sel_signal_bot=00100. Next cycle, with no new writes -> 10000 (tm1_bot).
- src_top=5 matching both mem_wb_top=5 and tm1_bot=5 -> sel_signal_top=00010 (newest wins).
- Store src_bot=2 with mem_wb_bot=2 and is_load=1 -> fwd_hold=1 for exactly one cycle. Next cycle FSM=HOLD, sel_bot=10000, fwd_hold=0. Following cycle RUN.
- src=0 with mem_wb_top=0 enabled, ZERO_REG_HW=1 -> select 00001, no hold.
- stall_in=1 for 3 cycles after a mem_wb_top=7 write -> tm1 unchanged, and FSM frozen. Then flush -> tm1 valids 0, so a src=7 select -> 00001.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants for the memory-stage store-data forwarding controller.
package fwd_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 4;

  // One-hot select encoding shared by the top-nibble and bottom-byte muxes.
  localparam logic [4:0] SEL_EXMEM   = 5'b00001;
  localparam logic [4:0] SEL_WB_TOP  = 5'b00010;
  localparam logic [4:0] SEL_WB_BOT  = 5'b00100;
  localparam logic [4:0] SEL_TM1_TOP = 5'b01000;
  localparam logic [4:0] SEL_TM1_BOT = 5'b10000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_src_prio.sv
// Newest-first priority match of one store source against four write slots.
module fwd_src_prio
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter bit          ZERO_REG_HW = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  wb_top_v_i,
  input  logic [REG_ADDR_W-1:0] wb_top_addr_i,
  input  logic                  wb_bot_v_i,
  input  logic [REG_ADDR_W-1:0] wb_bot_addr_i,
  input  logic                  tm1_top_v_i,
  input  logic [REG_ADDR_W-1:0] tm1_top_addr_i,
  input  logic                  tm1_bot_v_i,
  input  logic [REG_ADDR_W-1:0] tm1_bot_addr_i,
  output logic [4:0]            sel_o
);

  logic src_ok;

  // A hardwired zero register never takes forwarded data.
  assign src_ok = !(ZERO_REG_HW && (src_addr_i == '0));

  // Pick the youngest slot that writes the source register.
  always_comb begin
    sel_o = SEL_EXMEM;
    if (src_ok && wb_top_v_i && (wb_top_addr_i == src_addr_i)) begin
      sel_o = SEL_WB_TOP;
    end else if (src_ok && wb_bot_v_i && (wb_bot_addr_i == src_addr_i)) begin
      sel_o = SEL_WB_BOT;
    end else if (src_ok && tm1_top_v_i && (tm1_top_addr_i == src_addr_i)) begin
      sel_o = SEL_TM1_TOP;
    end else if (src_ok && tm1_bot_v_i && (tm1_bot_addr_i == src_addr_i)) begin
      sel_o = SEL_TM1_BOT;
    end
  end

endmodule

// File: rtl/mem_str_fwd_ctrl.sv
// Store-data forwarding select and store-after-load hold for the EX/MEM stage.
module mem_str_fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter bit          ZERO_REG_HW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  ex_mem_str_valid,
  input  logic [REG_ADDR_W-1:0] ex_mem_src_top_addr,
  input  logic [REG_ADDR_W-1:0] ex_mem_src_bot_addr,
  input  logic                  mem_wb_wr_top_en,
  input  logic [REG_ADDR_W-1:0] mem_wb_wr_top_addr,
  input  logic                  mem_wb_wr_bot_en,
  input  logic [REG_ADDR_W-1:0] mem_wb_wr_bot_addr,
  input  logic                  mem_wb_is_load,
  output logic [4:0]            sel_signal_top,
  output logic [4:0]            sel_signal_bot,
  output logic                  fwd_hold
);

  logic                  tm1_top_v_q;
  logic [REG_ADDR_W-1:0] tm1_top_addr_q;
  logic                  tm1_bot_v_q;
  logic [REG_ADDR_W-1:0] tm1_bot_addr_q;
  fwd_state_e            state_q;

  logic [4:0] prio_top;
  logic [4:0] prio_bot;
  logic       wb_hit;
  logic       hold_cond;

  fwd_src_prio #(
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) u_prio_top (
    .src_addr_i     (ex_mem_src_top_addr),
    .wb_top_v_i     (mem_wb_wr_top_en),
    .wb_top_addr_i  (mem_wb_wr_top_addr),
    .wb_bot_v_i     (mem_wb_wr_bot_en),
    .wb_bot_addr_i  (mem_wb_wr_bot_addr),
    .tm1_top_v_i    (tm1_top_v_q),
    .tm1_top_addr_i (tm1_top_addr_q),
    .tm1_bot_v_i    (tm1_bot_v_q),
    .tm1_bot_addr_i (tm1_bot_addr_q),
    .sel_o          (prio_top)
  );

  fwd_src_prio #(
    .REG_ADDR_W  (REG_ADDR_W),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) u_prio_bot (
    .src_addr_i     (ex_mem_src_bot_addr),
    .wb_top_v_i     (mem_wb_wr_top_en),
    .wb_top_addr_i  (mem_wb_wr_top_addr),
    .wb_bot_v_i     (mem_wb_wr_bot_en),
    .wb_bot_addr_i  (mem_wb_wr_bot_addr),
    .tm1_top_v_i    (tm1_top_v_q),
    .tm1_top_addr_i (tm1_top_addr_q),
    .tm1_bot_v_i    (tm1_bot_v_q),
    .tm1_bot_addr_i (tm1_bot_addr_q),
    .sel_o          (prio_bot)
  );

  assign sel_signal_top = ex_mem_str_valid ? prio_top : SEL_EXMEM;
  assign sel_signal_bot = ex_mem_str_valid ? prio_bot : SEL_EXMEM;

  // Load data in MEM/WB arrives a cycle late, so a store consuming it must wait.
  assign wb_hit    = sel_signal_top[1] | sel_signal_top[2] | sel_signal_bot[1] | sel_signal_bot[2];
  assign hold_cond = (state_q == RUN) & ex_mem_str_valid & mem_wb_is_load & wb_hit & ~stall_in;
  assign fwd_hold  = hold_cond;

  // One-cycle-older copy of the MEM/WB write destinations.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tm1_top_v_q    <= 1'b0;
      tm1_top_addr_q <= '0;
      tm1_bot_v_q    <= 1'b0;
      tm1_bot_addr_q <= '0;
    end else if (flush) begin
      tm1_top_v_q <= 1'b0;
      tm1_bot_v_q <= 1'b0;
    end else if (!stall_in) begin
      tm1_top_v_q    <= mem_wb_wr_top_en;
      tm1_top_addr_q <= mem_wb_wr_top_addr;
      tm1_bot_v_q    <= mem_wb_wr_bot_en;
      tm1_bot_addr_q <= mem_wb_wr_bot_addr;
    end
  end

  // HOLD lasts one unstalled cycle and never re-triggers, so each store holds at most once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else if (flush) begin
      state_q <= RUN;
    end else if (!stall_in) begin
      unique case (state_q)
        RUN:     state_q <= hold_cond ? HOLD : RUN;
        HOLD:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_str_fwd_ctrl.sv
// Self-checking bench: directed scenarios then random traffic against a reference model.
module tb_mem_str_fwd_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       stall_in = 1'b0;
  logic       flush = 1'b0;
  logic       ex_mem_str_valid = 1'b0;
  logic [3:0] ex_mem_src_top_addr = 4'd0;
  logic [3:0] ex_mem_src_bot_addr = 4'd0;
  logic       mem_wb_wr_top_en = 1'b0;
  logic [3:0] mem_wb_wr_top_addr = 4'd0;
  logic       mem_wb_wr_bot_en = 1'b0;
  logic [3:0] mem_wb_wr_bot_addr = 4'd0;
  logic       mem_wb_is_load = 1'b0;
  logic [4:0] sel_signal_top;
  logic [4:0] sel_signal_bot;
  logic       fwd_hold;

  always #5 clock = ~clock;

  mem_str_fwd_ctrl #(
    .REG_ADDR_W  (4),
    .ZERO_REG_HW (1'b1)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .stall_in            (stall_in),
    .flush               (flush),
    .ex_mem_str_valid    (ex_mem_str_valid),
    .ex_mem_src_top_addr (ex_mem_src_top_addr),
    .ex_mem_src_bot_addr (ex_mem_src_bot_addr),
    .mem_wb_wr_top_en    (mem_wb_wr_top_en),
    .mem_wb_wr_top_addr  (mem_wb_wr_top_addr),
    .mem_wb_wr_bot_en    (mem_wb_wr_bot_en),
    .mem_wb_wr_bot_addr  (mem_wb_wr_bot_addr),
    .mem_wb_is_load      (mem_wb_is_load),
    .sel_signal_top      (sel_signal_top),
    .sel_signal_bot      (sel_signal_bot),
    .fwd_hold            (fwd_hold)
  );

  // Reference model: previous cycle's writes and whether the last cycle raised a hold.
  logic       m_top_v = 1'b0;
  logic [3:0] m_top_a = 4'd0;
  logic       m_bot_v = 1'b0;
  logic [3:0] m_bot_a = 4'd0;
  logic       m_in_hold = 1'b0;

  logic [4:0] e_top;
  logic [4:0] e_bot;
  logic       e_hold;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Newest writer of src wins; bit index = 1 + age rank of the slot.
  function automatic logic [4:0] ref_sel(input logic [3:0] src);
    logic [3:0] en;
    logic [3:0] ad [4];
    if (!ex_mem_str_valid || src == 4'd0) return 5'b00001;
    en    = {m_bot_v, m_top_v, mem_wb_wr_bot_en, mem_wb_wr_top_en};
    ad[0] = mem_wb_wr_top_addr;
    ad[1] = mem_wb_wr_bot_addr;
    ad[2] = m_top_a;
    ad[3] = m_bot_a;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && ad[i] == src) return 5'(1 << (i + 1));
    end
    return 5'b00001;
  endfunction

  task automatic compute();
    e_top  = ref_sel(ex_mem_src_top_addr);
    e_bot  = ref_sel(ex_mem_src_bot_addr);
    e_hold = !m_in_hold && ex_mem_str_valid && mem_wb_is_load && !stall_in &&
             (e_top[1] || e_top[2] || e_bot[1] || e_bot[2]);
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    compute();
    chk5({tag, "_top"}, sel_signal_top, e_top);
    chk5({tag, "_bot"}, sel_signal_bot, e_bot);
    chk1({tag, "_hold"}, fwd_hold, e_hold);
  endtask

  task automatic model_reset();
    m_top_v   = 1'b0;
    m_top_a   = 4'd0;
    m_bot_v   = 1'b0;
    m_bot_a   = 4'd0;
    m_in_hold = 1'b0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_top_v   = 1'b0;
      m_bot_v   = 1'b0;
      m_in_hold = 1'b0;
    end else if (!stall_in) begin
      m_top_v   = mem_wb_wr_top_en;
      m_top_a   = mem_wb_wr_top_addr;
      m_bot_v   = mem_wb_wr_bot_en;
      m_bot_a   = mem_wb_wr_bot_addr;
      m_in_hold = e_hold;
    end
  endtask

  // Inputs are set 1 time unit after a rising edge; outputs checked mid-cycle.
  task automatic cyc(input string tag);
    #2;
    check_all(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    stall_in            = 1'b0;
    flush               = 1'b0;
    ex_mem_str_valid    = 1'b0;
    ex_mem_src_top_addr = 4'd0;
    ex_mem_src_bot_addr = 4'd0;
    mem_wb_wr_top_en    = 1'b0;
    mem_wb_wr_top_addr  = 4'd0;
    mem_wb_wr_bot_en    = 1'b0;
    mem_wb_wr_bot_addr  = 4'd0;
    mem_wb_is_load      = 1'b0;
  endtask

  initial begin
    // Reset with no stimulus.
    idle();
    #3;
    check_all("rst");
    chk5("rst_top_const", sel_signal_top, 5'b00001);
    chk1("rst_hold_const", fwd_hold, 1'b0);
    @(posedge clock);
    #1;
    check_all("rst_edge");
    reset_n = 1'b1;

    // Store with no writes anywhere.
    ex_mem_str_valid = 1'b1;
    ex_mem_src_top_addr = 4'd3;
    ex_mem_src_bot_addr = 4'd6;
    cyc("idle_str");

    // MEM/WB bottom forward, then the same write seen from tm1.
    idle();
    ex_mem_str_valid = 1'b1;
    ex_mem_src_bot_addr = 4'd3;
    mem_wb_wr_bot_en = 1'b1;
    mem_wb_wr_bot_addr = 4'd3;
    #1;
    chk5("wb_bot_const", sel_signal_bot, 5'b00100);
    cyc("wb_bot");
    mem_wb_wr_bot_en = 1'b0;
    #1;
    chk5("tm1_bot_const", sel_signal_bot, 5'b10000);
    cyc("tm1_bot");

    // Newest source beats older tm1 copy.
    idle();
    mem_wb_wr_bot_en = 1'b1;
    mem_wb_wr_bot_addr = 4'd5;
    cyc("prep_tm1_5");
    idle();
    ex_mem_str_valid = 1'b1;
    ex_mem_src_top_addr = 4'd5;
    mem_wb_wr_top_en = 1'b1;
    mem_wb_wr_top_addr = 4'd5;
    #1;
    chk5("newest_const", sel_signal_top, 5'b00010);
    cyc("newest");

    // Store-after-load: one hold cycle, then tm1 select, then back in RUN.
    idle();
    ex_mem_str_valid = 1'b1;
    ex_mem_src_bot_addr = 4'd2;
    mem_wb_wr_bot_en = 1'b1;
    mem_wb_wr_bot_addr = 4'd2;
    mem_wb_is_load = 1'b1;
    #1;
    chk1("haz_hold_const", fwd_hold, 1'b1);
    cyc("haz");
    mem_wb_wr_bot_en = 1'b0;
    mem_wb_is_load = 1'b0;
    #1;
    chk5("haz_tm1_const", sel_signal_bot, 5'b10000);
    chk1("haz_nohold_const", fwd_hold, 1'b0);
    cyc("in_hold");
    mem_wb_wr_bot_en = 1'b1;
    mem_wb_is_load = 1'b1;
    cyc("haz_again");

    // Reset while in HOLD.
    idle();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ex_mem_str_valid = 1'b1;
    ex_mem_src_bot_addr = 4'd2;
    cyc("post_rst");

    // Zero register never forwards and never holds.
    idle();
    ex_mem_str_valid = 1'b1;
    ex_mem_src_top_addr = 4'd0;
    mem_wb_wr_top_en = 1'b1;
    mem_wb_wr_top_addr = 4'd0;
    mem_wb_is_load = 1'b1;
    #1;
    chk5("zero_const", sel_signal_top, 5'b00001);
    cyc("zero");

    // Load that matches nothing.
    ex_mem_src_top_addr = 4'd9;
    mem_wb_wr_top_addr = 4'd4;
    cyc("load_nomatch");

    // Stall freezes history and FSM; flush then clears history.
    idle();
    mem_wb_wr_top_en = 1'b1;
    mem_wb_wr_top_addr = 4'd7;
    cyc("prep_7");
    idle();
    stall_in = 1'b1;
    ex_mem_str_valid = 1'b1;
    ex_mem_src_top_addr = 4'd7;
    ex_mem_src_bot_addr = 4'd3;
    mem_wb_wr_top_en = 1'b1;
    mem_wb_wr_top_addr = 4'd3;
    mem_wb_is_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk5("stall_tm1_const", sel_signal_top, 5'b01000);
      cyc("stall");
    end
    flush = 1'b1;
    cyc("flush");
    idle();
    ex_mem_str_valid = 1'b1;
    ex_mem_src_top_addr = 4'd7;
    #1;
    chk5("post_flush_const", sel_signal_top, 5'b00001);
    cyc("post_flush");

    // Random traffic on a small address range to force frequent matches.
    for (int n = 0; n < 600; n++) begin
      ex_mem_str_valid    = ($urandom_range(0, 3) != 0);
      ex_mem_src_top_addr = 4'($urandom_range(0, 3));
      ex_mem_src_bot_addr = 4'($urandom_range(0, 3));
      mem_wb_wr_top_en    = ($urandom_range(0, 1) != 0);
      mem_wb_wr_top_addr  = 4'($urandom_range(0, 3));
      mem_wb_wr_bot_en    = ($urandom_range(0, 1) != 0);
      mem_wb_wr_bot_addr  = 4'($urandom_range(0, 3));
      mem_wb_is_load      = ($urandom_range(0, 9) < 3);
      stall_in            = ($urandom_range(0, 19) < 3);
      flush               = ($urandom_range(0, 19) == 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
